// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard scoreboard: operand forwarding, load-use / mul-div stalls,
// branch flush sequencing and the multi-cycle mul/div writeback tracker.
module hazard_scoreboard_unit #(
   parameter int RADDR_W    = 5,
   parameter int MD_LAT     = 4,
   parameter int BR_PENALTY = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               issue_valid_ID,
   input  logic               rs1use_ID,
   input  logic               rs2use_ID,
   input  logic [RADDR_W-1:0] rs1_ID,
   input  logic [RADDR_W-1:0] rs2_ID,
   input  logic [RADDR_W-1:0] rd_ID,
   input  logic [2:0]         optype_ID,
   input  logic               br_taken_EXE,
   output logic               PC_EN_IF,
   output logic               reg_FD_EN,
   output logic               reg_FD_flush,
   output logic               reg_DE_flush,
   output logic [1:0]         forward_ctrl_A,
   output logic [1:0]         forward_ctrl_B,
   output logic               md_busy,
   output logic               md_wb
);

   localparam logic [2:0] OP_ALU  = 3'b001;
   localparam logic [2:0] OP_LOAD = 3'b010;
   localparam logic [2:0] OP_MD   = 3'b100;

   typedef enum logic {
      MD_IDLE,
      MD_BUSY
   } md_state_t;

   logic               exe_valid, mem_valid;
   logic [RADDR_W-1:0] exe_rd, mem_rd;
   logic [2:0]         exe_op, mem_op;

   md_state_t          md_state, md_state_nx;
   logic [3:0]         md_cnt, md_cnt_nx;
   logic [RADDR_W-1:0] md_rd, md_rd_nx;
   logic [1:0]         fl_cnt;

   logic stall, flush, issue;
   logic load_use, md_struct, md_raw, md_waw, md_active;
   logic a_exe_hit, a_mem_hit, b_exe_hit, b_mem_hit;

   // Only ALU and load results are ever forwardable; mul/div results are not.
   function automatic logic src_match(
      input logic               use_src,
      input logic [RADDR_W-1:0] rs,
      input logic               slot_valid,
      input logic [RADDR_W-1:0] slot_rd,
      input logic [2:0]         slot_op
   );
      return use_src && (rs != '0) && slot_valid && (slot_rd == rs) &&
             ((slot_op == OP_ALU) || (slot_op == OP_LOAD));
   endfunction

   // A load in EXE shadows any older MEM producer; the stall covers that case.
   function automatic logic [1:0] fwd_sel(
      input logic       exe_hit,
      input logic       mem_hit,
      input logic [2:0] e_op,
      input logic [2:0] m_op
   );
      logic [1:0] sel;
      sel = 2'b00;
      if (exe_hit) begin
         sel = (e_op == OP_ALU) ? 2'b01 : 2'b00;
      end else if (mem_hit) begin
         sel = (m_op == OP_ALU) ? 2'b10 : 2'b11;
      end
      return sel;
   endfunction

   always_comb begin
      a_exe_hit = src_match(rs1use_ID, rs1_ID, exe_valid, exe_rd, exe_op);
      a_mem_hit = src_match(rs1use_ID, rs1_ID, mem_valid, mem_rd, mem_op);
      b_exe_hit = src_match(rs2use_ID, rs2_ID, exe_valid, exe_rd, exe_op);
      b_mem_hit = src_match(rs2use_ID, rs2_ID, mem_valid, mem_rd, mem_op);
      forward_ctrl_A = fwd_sel(a_exe_hit, a_mem_hit, exe_op, mem_op);
      forward_ctrl_B = fwd_sel(b_exe_hit, b_mem_hit, exe_op, mem_op);
   end

   // Hazard detection; a zero md_rd never matches since x0 is never a real dependency.
   always_comb begin
      md_active = (md_state == MD_BUSY);
      load_use  = (exe_op == OP_LOAD) && (a_exe_hit || b_exe_hit);
      md_struct = md_active && (optype_ID == OP_MD);
      md_raw    = md_active && (md_rd != '0) &&
                  ((rs1use_ID && (rs1_ID == md_rd)) || (rs2use_ID && (rs2_ID == md_rd)));
      md_waw    = md_active && (rd_ID != '0) && (rd_ID == md_rd);
      stall     = issue_valid_ID && (load_use || md_struct || md_raw || md_waw);
      flush     = !rst && (br_taken_EXE || (fl_cnt != 2'd0));
      issue     = issue_valid_ID && !stall && !flush;
   end

   // Flush wins over stall: the stalled instruction is on the wrong path anyway.
   always_comb begin
      PC_EN_IF     = 1'b1;
      reg_FD_EN    = 1'b1;
      reg_FD_flush = 1'b0;
      reg_DE_flush = 1'b0;
      if (flush) begin
         reg_FD_flush = 1'b1;
         reg_DE_flush = 1'b1;
      end else if (stall) begin
         PC_EN_IF     = 1'b0;
         reg_FD_EN    = 1'b0;
         reg_DE_flush = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         exe_valid <= 1'b0;
         exe_rd    <= '0;
         exe_op    <= 3'b000;
         mem_valid <= 1'b0;
         mem_rd    <= '0;
         mem_op    <= 3'b000;
      end else begin
         exe_valid <= issue;
         exe_rd    <= issue ? rd_ID : '0;
         exe_op    <= issue ? optype_ID : 3'b000;
         mem_valid <= exe_valid;
         mem_rd    <= exe_rd;
         mem_op    <= exe_op;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fl_cnt <= 2'd0;
      end else if (br_taken_EXE) begin
         fl_cnt <= 2'(BR_PENALTY);
      end else if (fl_cnt != 2'd0) begin
         fl_cnt <= fl_cnt - 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         md_state <= MD_IDLE;
         md_cnt   <= 4'd0;
         md_rd    <= '0;
      end else begin
         md_state <= md_state_nx;
         md_cnt   <= md_cnt_nx;
         md_rd    <= md_rd_nx;
      end
   end

   // The mul/div is older than any branch in EXE, so flushes never cancel it.
   always_comb begin
      md_state_nx = md_state;
      md_cnt_nx   = md_cnt;
      md_rd_nx    = md_rd;
      md_busy     = 1'b0;
      md_wb       = 1'b0;
      case (md_state)
         MD_IDLE: begin
            if (issue && (optype_ID == OP_MD)) begin
               md_state_nx = MD_BUSY;
               md_cnt_nx   = 4'(MD_LAT - 1);
               md_rd_nx    = rd_ID;
            end
         end
         MD_BUSY: begin
            md_busy = 1'b1;
            if (md_cnt == 4'd0) begin
               md_wb       = 1'b1;
               md_state_nx = MD_IDLE;
            end else begin
               md_cnt_nx = md_cnt - 4'd1;
            end
         end
         default: md_state_nx = MD_IDLE;
      endcase
   end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a cycle-count based model.
module tb_hazard_scoreboard_unit;

   localparam int MD_LAT = 4;
   localparam int BR_P   = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       issue_valid_ID = 1'b0;
   logic       rs1use_ID = 1'b0, rs2use_ID = 1'b0;
   logic [4:0] rs1_ID = '0, rs2_ID = '0, rd_ID = '0;
   logic [2:0] optype_ID = '0;
   logic       br_taken_EXE = 1'b0;
   logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush, md_busy, md_wb;
   logic [1:0] forward_ctrl_A, forward_ctrl_B;

   hazard_scoreboard_unit #(.RADDR_W(5), .MD_LAT(MD_LAT), .BR_PENALTY(BR_P)) dut (
      .clk(clk), .rst(rst),
      .issue_valid_ID(issue_valid_ID),
      .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
      .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
      .optype_ID(optype_ID), .br_taken_EXE(br_taken_EXE),
      .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
      .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
      .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
      .md_busy(md_busy), .md_wb(md_wb)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit check_en = 1'b0;
   logic rst_next = 1'b1;

   typedef struct {
      bit         v;
      logic [4:0] rd;
      logic [2:0] op;
   } ent_t;

   // Model: instructions issued one and two cycles ago, plus the cycle numbers
   // of the last mul/div issue and the last taken branch.
   int         cyc = 0;
   int         md_issue = -1;
   logic [4:0] m_md_rd = '0;
   int         last_br = -100;
   ent_t       m_exe, m_mem;
   bit         m_issue;
   logic       exp_pc, exp_fd_en, exp_fd_fl, exp_de_fl, exp_busy, exp_wb;
   logic [1:0] exp_fa, exp_fb;

   task automatic model_reset();
      md_issue = -1;
      m_md_rd  = '0;
      last_br  = -100;
      m_exe    = '{v: 1'b0, rd: 5'd0, op: 3'd0};
      m_mem    = '{v: 1'b0, rd: 5'd0, op: 3'd0};
   endtask

   function automatic logic [1:0] model_fwd(input logic use_src, input logic [4:0] rs);
      if (!use_src || rs == 5'd0) return 2'd0;
      if (m_exe.v && m_exe.rd == rs && (m_exe.op == 3'd1 || m_exe.op == 3'd2))
         return (m_exe.op == 3'd1) ? 2'd1 : 2'd0;
      if (m_mem.v && m_mem.rd == rs && (m_mem.op == 3'd1 || m_mem.op == 3'd2))
         return (m_mem.op == 3'd1) ? 2'd2 : 2'd3;
      return 2'd0;
   endfunction

   task automatic model_eval();
      bit busy, lu, raw, waw, strc, stall, flush;
      busy  = (md_issue >= 0) && (cyc > md_issue) && (cyc <= md_issue + MD_LAT);
      lu    = m_exe.v && (m_exe.op == 3'd2) &&
              ((rs1use_ID && rs1_ID != 0 && rs1_ID == m_exe.rd) ||
               (rs2use_ID && rs2_ID != 0 && rs2_ID == m_exe.rd));
      raw   = busy && m_md_rd != 0 &&
              ((rs1use_ID && rs1_ID == m_md_rd) || (rs2use_ID && rs2_ID == m_md_rd));
      waw   = busy && rd_ID != 0 && rd_ID == m_md_rd;
      strc  = busy && optype_ID == 3'd4;
      stall = issue_valid_ID && (lu || raw || waw || strc);
      flush = !rst && (br_taken_EXE || (cyc - last_br <= BR_P));
      m_issue   = issue_valid_ID && !stall && !flush && !rst;
      exp_busy  = busy;
      exp_wb    = busy && (cyc == md_issue + MD_LAT);
      exp_fa    = model_fwd(rs1use_ID, rs1_ID);
      exp_fb    = model_fwd(rs2use_ID, rs2_ID);
      exp_pc    = flush || !stall;
      exp_fd_en = flush || !stall;
      exp_fd_fl = flush;
      exp_de_fl = flush || stall;
   endtask

   task automatic model_clock();
      if (rst) begin
         model_reset();
      end else begin
         if (m_issue && optype_ID == 3'd4) begin
            md_issue = cyc;
            m_md_rd  = rd_ID;
         end
         m_mem = m_exe;
         m_exe = m_issue ? '{v: 1'b1, rd: rd_ID, op: optype_ID} : '{v: 1'b0, rd: 5'd0, op: 3'd0};
         if (br_taken_EXE) last_br = cyc;
      end
      cyc++;
   endtask

   task automatic check_output(input string name, input logic [1:0] act, input logic [1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
      end
   endtask

   task automatic apply_stimulus(input logic v, input logic [2:0] op,
                                 input logic [4:0] r1, input logic u1,
                                 input logic [4:0] r2, input logic u2,
                                 input logic [4:0] rd, input logic br);
      @(posedge clk);
      model_clock();
      #1;
      rst = rst_next;
      if (rst) model_reset();
      issue_valid_ID = v;  optype_ID = op;
      rs1_ID = r1; rs1use_ID = u1;
      rs2_ID = r2; rs2use_ID = u2;
      rd_ID  = rd; br_taken_EXE = br;
      model_eval();
      check_en = 1'b1;
      #1;
   endtask

   task automatic do_reset();
      rst_next = 1'b1;
      apply_stimulus(1'b1, 3'd1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1);
      check_output("rst_pc_en", {1'b0, PC_EN_IF}, 2'd1);
      check_output("rst_fd_flush", {1'b0, reg_FD_flush}, 2'd0);
      rst_next = 1'b0;
      apply_stimulus(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   // Every-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (check_en) begin
         check_output("pc_en",     {1'b0, PC_EN_IF},     {1'b0, exp_pc});
         check_output("fd_en",     {1'b0, reg_FD_EN},    {1'b0, exp_fd_en});
         check_output("fd_flush",  {1'b0, reg_FD_flush}, {1'b0, exp_fd_fl});
         check_output("de_flush",  {1'b0, reg_DE_flush}, {1'b0, exp_de_fl});
         check_output("fwd_a",     forward_ctrl_A,       exp_fa);
         check_output("fwd_b",     forward_ctrl_B,       exp_fb);
         check_output("md_busy",   {1'b0, md_busy},      {1'b0, exp_busy});
         check_output("md_wb",     {1'b0, md_wb},        {1'b0, exp_wb});
      end
   end

   initial begin
      model_reset();
      do_reset();

      // ALU chain: x5 -> x6 -> x7
      apply_stimulus(1'b1, 3'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0);
      apply_stimulus(1'b1, 3'd1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b0);
      check_output("chain2_fa", forward_ctrl_A, 2'd1);
      check_output("chain2_fb", forward_ctrl_B, 2'd1);
      apply_stimulus(1'b1, 3'd1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b0);
      check_output("chain3_fa", forward_ctrl_A, 2'd2);
      check_output("chain3_fb", forward_ctrl_B, 2'd1);
      check_output("chain3_pc", {1'b0, PC_EN_IF}, 2'd1);

      // Load-use: lw x3; add x4,x3,x0
      do_reset();
      apply_stimulus(1'b1, 3'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0);
      apply_stimulus(1'b1, 3'd1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0);
      check_output("lu_stall_pc", {1'b0, PC_EN_IF}, 2'd0);
      check_output("lu_stall_de", {1'b0, reg_DE_flush}, 2'd1);
      apply_stimulus(1'b1, 3'd1, 5'd3, 1'b1, 5'd0, 1'b1, 5'd4, 1'b0);
      check_output("lu_fwd_a", forward_ctrl_A, 2'd3);
      check_output("lu_release_pc", {1'b0, PC_EN_IF}, 2'd1);

      // Mul/div RAW: mul x8 at cycle 0, dependent add released at cycle 5
      do_reset();
      apply_stimulus(1'b1, 3'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b0);
      check_output("md_c0_busy", {1'b0, md_busy}, 2'd0);
      for (int k = 1; k <= 5; k++) begin
         apply_stimulus(1'b1, 3'd1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0);
         check_output("md_raw_busy", {1'b0, md_busy}, (k <= 4) ? 2'd1 : 2'd0);
         check_output("md_raw_wb",   {1'b0, md_wb},   (k == 4) ? 2'd1 : 2'd0);
         check_output("md_raw_pc",   {1'b0, PC_EN_IF}, (k <= 4) ? 2'd0 : 2'd1);
      end

      // Back-to-back mul/div with the same rd (structural + WAW)
      do_reset();
      apply_stimulus(1'b1, 3'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         apply_stimulus(1'b1, 3'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b0);
         check_output("md_b2b_pc", {1'b0, PC_EN_IF}, (k <= 4) ? 2'd0 : 2'd1);
      end
      apply_stimulus(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      check_output("md_b2b_busy2", {1'b0, md_busy}, 2'd1);

      // Branch with penalty 2 over a load-use stall and an in-flight mul/div
      do_reset();
      apply_stimulus(1'b1, 3'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b0);
      apply_stimulus(1'b1, 3'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0);
      for (int k = 2; k <= 5; k++) begin
         apply_stimulus(1'b1, 3'd1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd4, (k == 2));
         check_output("br_fd_flush", {1'b0, reg_FD_flush}, (k <= 4) ? 2'd1 : 2'd0);
         check_output("br_pc",       {1'b0, PC_EN_IF}, 2'd1);
         check_output("br_md_wb",    {1'b0, md_wb}, (k == 4) ? 2'd1 : 2'd0);
      end

      // Asynchronous reset while the mul/div counter is at 2
      do_reset();
      apply_stimulus(1'b1, 3'd4, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b0);
      apply_stimulus(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      apply_stimulus(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      check_output("arst_pre_busy", {1'b0, md_busy}, 2'd1);
      #1;
      rst = 1'b1;
      rst_next = 1'b1;
      model_reset();
      model_eval();
      #1;
      check_output("arst_busy", {1'b0, md_busy}, 2'd0);
      check_output("arst_wb",   {1'b0, md_wb}, 2'd0);
      check_output("arst_de",   {1'b0, reg_DE_flush}, 2'd0);
      apply_stimulus(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      rst_next = 1'b0;
      for (int k = 0; k < 4; k++) begin
         apply_stimulus(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
         check_output("arst_no_wb", {1'b0, md_wb}, 2'd0);
      end

      // Randomized traffic over a small register set so hazards are frequent
      for (int n = 0; n < 3000; n++) begin
         rst_next = ($urandom_range(0, 299) == 0);
         apply_stimulus($urandom_range(0, 9) < 8, 3'($urandom_range(0, 4)),
                        5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                        5'($urandom_range(0, 3)), $urandom_range(0, 99) < 8);
      end

      @(posedge clk);
      check_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard_unit.md
HAZARD_SCOREBOARD_UNIT -- requirements
Module: hazard_scoreboard_unit

Interface
REQ-001 The block SHALL have parameter RADDR_W, default 5, meaning the register address width.
REQ-002 The block SHALL have parameter MD_LAT, default 4, range 2..15, meaning the cycles from mul/div issue to regfile write.
REQ-003 The block SHALL have parameter BR_PENALTY, default 1, range 1..3, meaning the flush cycles after a taken branch.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-006 The block SHALL have port issue_valid_ID, input, 1, meaning ID holds a valid instruction.
REQ-007 The block SHALL have ports rs1use_ID and rs2use_ID, input, 1 each, meaning the source operand is read.
REQ-008 The block SHALL have ports rs1_ID, rs2_ID and rd_ID, input, RADDR_W each, meaning the ID register fields.
REQ-009 The block SHALL have port optype_ID, input, 3, meaning the ID operation type: 000 none, 001 ALU, 010 load, 011 branch, 100 mul/div.
REQ-010 The block SHALL have port br_taken_EXE, input, 1, meaning a branch or jump resolved taken in EXE.
REQ-011 The block SHALL have ports PC_EN_IF and reg_FD_EN, output, 1 each, meaning the fetch and IF/ID enables.
REQ-012 The block SHALL have ports reg_FD_flush and reg_DE_flush, output, 1 each, meaning bubble insertion into IF/ID and ID/EX.
REQ-013 The block SHALL have ports forward_ctrl_A and forward_ctrl_B, output, 2 each: 00 regfile, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data.
REQ-014 The block SHALL have port md_busy, output, 1, meaning a mul/div is in flight.
REQ-015 The block SHALL have port md_wb, output, 1, a one-cycle pulse on the mul/div regfile write cycle.

Function
REQ-016 The block SHALL track two internal slots, EXE and MEM, each holding {valid, rd, optype}.
REQ-017 An instruction SHALL issue when issue_valid_ID=1, stall=0 and flush=0.
REQ-018 Each cycle, EXE SHALL load the issuing instruction (or a bubble), and MEM SHALL load the previous EXE slot.
REQ-019 A slot SHALL match a source operand when rsXuse_ID=1, rsX_ID!=0, the slot is valid, the slot rd equals rsX_ID, and the slot optype is ALU or load.
REQ-020 Forwarding SHALL prefer EXE over MEM: EXE ALU gives 01, MEM ALU gives 10, MEM load gives 11, otherwise 00.
REQ-021 forward_ctrl SHALL be combinational from the slots and the ID fields.
REQ-022 Load-use stall: a matching EXE-slot load SHALL assert stall for exactly 1 cycle, after which the load is in MEM and forwarded with 11.
REQ-023 The mul/div FSM SHALL have states IDLE and BUSY.
REQ-024 In IDLE, issuing optype 100 SHALL capture rd into md_rd, load md_cnt=MD_LAT-1 and go to BUSY.
REQ-025 In BUSY, md_cnt SHALL decrement each cycle; when md_cnt=0, md_wb=1 and the FSM SHALL return to IDLE.
REQ-026 md_busy SHALL be 1 in BUSY.
REQ-027 Structural stall: optype 100 in ID while BUSY, including the md_wb cycle, SHALL stall.
REQ-028 RAW stall: rsX_ID equal to md_rd, non-zero and used, while BUSY SHALL stall; mul/div results are not forwarded, and the reader is released the cycle after md_wb.
REQ-029 WAW stall: any issuing instruction with rd_ID=md_rd, rd!=0, while BUSY SHALL stall.
REQ-030 stall SHALL be the OR of REQ-022 and REQ-027 to REQ-029.
REQ-031 On stall: PC_EN_IF=0, reg_FD_EN=0 and reg_DE_flush=1.
REQ-032 br_taken_EXE SHALL load flush counter fl_cnt=BR_PENALTY.
REQ-033 Flush SHALL be active in the br_taken_EXE cycle and while fl_cnt!=0.
REQ-034 While flush is active: reg_FD_flush=1, reg_DE_flush=1, PC_EN_IF=1, reg_FD_EN=1 and no issue.
REQ-035 fl_cnt SHALL decrement to 0 while flush is active.
REQ-036 Flush SHALL override stall in the same cycle.
REQ-037 An in-flight mul/div SHALL NOT be cancelled by a flush, because it is older than the branch.
REQ-038 br_taken_EXE during an active flush SHALL reload fl_cnt=BR_PENALTY.
REQ-039 A mul/div with rd=0 SHALL still occupy BUSY but SHALL cause no RAW or WAW stalls.

Reset
REQ-040 rst=1 SHALL immediately clear the EXE/MEM slots, set the FSM to IDLE, and clear md_cnt, md_rd and fl_cnt.
REQ-041 During and after reset: PC_EN_IF=1, reg_FD_EN=1, both flush outputs=0, forward_ctrl=00, md_busy=0 and md_wb=0.
REQ-042 Reset asserted mid mul/div SHALL abort the operation with no md_wb pulse.

Verification
REQ-043 Scenario ALU chain: add x5; add x6,x5,x5; add x7,x5,x6 -> forward_ctrl A=B=01 for the second instruction; A=10, B=01 for the third; no stall.
REQ-044 Scenario load-use: lw x3; add x4,x3,x0 -> 1 stall cycle (PC_EN_IF=0, reg_DE_flush=1), then forward_ctrl_A=11.
REQ-045 Scenario mul/div RAW with MD_LAT=4: mul x8 at cycle 0; add x9,x8 issues at cycle 5; md_wb=1 at cycle 4; md_busy=1 in cycles 1-4.
REQ-046 Scenario back-to-back mul/div: the second mul/div stalls until the cycle after md_wb; the WAW case with the same rd also stalls.
REQ-047 Scenario branch with BR_PENALTY=2 and a concurrent load-use stall: reg_FD_flush=1 for 3 cycles, no stall outputs, and an in-flight mul/div still pulses md_wb.
REQ-048 Scenario reset: rst=1 at BUSY md_cnt=2 -> md_busy=0 asynchronously, no md_wb pulse, and all outputs at reset values.
